// File: rtl/clint_rtc_gen.sv
// NCO-based real-time-clock reference for the CLINT rtc_i input.
// Rate changes are staged and only applied at a period boundary, or immediately while disabled.
module clint_rtc_gen #(
    parameter int unsigned AccWidth      = 32,
    parameter int unsigned MinHalfPeriod = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [AccWidth-1:0] cfg_inc_i,
    output logic                cfg_err_o,
    output logic                rtc_o,
    output logic                tick_o,
    output logic [31:0]         tick_cnt_o
);

    localparam int unsigned HalfShift = $clog2(MinHalfPeriod);
    // Largest increment that keeps every half period at least MinHalfPeriod cycles.
    localparam logic [AccWidth-1:0] IncMax = {1'b1, {(AccWidth-1){1'b0}}} >> HalfShift;

    function automatic logic [AccWidth-1:0] clamp_inc(input logic [AccWidth-1:0] inc);
        if (inc > IncMax) begin
            clamp_inc = IncMax;
        end else begin
            clamp_inc = inc;
        end
    endfunction

    logic [AccWidth-1:0] acc_q, acc_d;
    logic [AccWidth-1:0] inc_q, inc_d;
    logic [AccWidth-1:0] pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                tick_q, tick_d;
    logic [31:0]         tick_cnt_q, tick_cnt_d;

    logic [AccWidth:0]   sum_s;
    logic                carry_s;
    logic                accept_s;

    // Next-state: phase accumulation, staged increment hand-over and config handshake.
    always_comb begin
        sum_s        = {1'b0, acc_q} + {1'b0, inc_q};
        carry_s      = sum_s[AccWidth];
        accept_s     = cfg_valid_i && ready_q;
        acc_d        = acc_q;
        inc_d        = inc_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        err_d        = err_q;
        tick_d       = 1'b0;

        if (en_i) begin
            acc_d  = sum_s[AccWidth-1:0];
            tick_d = !acc_q[AccWidth-1] && sum_s[AccWidth-1];
            if (carry_s && pend_valid_q) begin
                inc_d        = pend_q;
                pend_valid_d = 1'b0;
            end else begin
                inc_d        = inc_q;
                pend_valid_d = pend_valid_q;
            end
        end else begin
            acc_d  = {AccWidth{1'b0}};
            tick_d = 1'b0;
            if (pend_valid_q) begin
                inc_d        = pend_q;
                pend_valid_d = 1'b0;
            end else begin
                inc_d        = inc_q;
                pend_valid_d = pend_valid_q;
            end
        end

        // Ready is low whenever a value is pending, so acceptance never collides with an apply.
        if (accept_s) begin
            pend_d       = clamp_inc(cfg_inc_i);
            pend_valid_d = 1'b1;
            err_d        = err_q || (cfg_inc_i > IncMax);
        end else begin
            pend_d = pend_q;
            err_d  = err_q;
        end

        ready_d = !pend_valid_d;

        if (tick_d) begin
            tick_cnt_d = tick_cnt_q + 32'd1;
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q        <= {AccWidth{1'b0}};
            inc_q        <= {AccWidth{1'b0}};
            pend_q       <= {AccWidth{1'b0}};
            pend_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            err_q        <= 1'b0;
            tick_q       <= 1'b0;
            tick_cnt_q   <= 32'd0;
        end else begin
            acc_q        <= acc_d;
            inc_q        <= inc_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            tick_q       <= tick_d;
            tick_cnt_q   <= tick_cnt_d;
        end
    end

    assign rtc_o       = acc_q[AccWidth-1];
    assign tick_o      = tick_q;
    assign tick_cnt_o  = tick_cnt_q;
    assign cfg_ready_o = ready_q;
    assign cfg_err_o   = err_q;

endmodule

// File: tb/tb_clint_rtc_gen.sv
// Scoreboard bench for clint_rtc_gen (AccWidth=8, MinHalfPeriod=2, IncMax=64).
module tb_clint_rtc_gen;

    localparam int AW = 8;
    localparam int S_RTC = 0, S_TICK = 1, S_CNT = 2, S_RDY = 3, S_ERR = 4, S_ACC = 5;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [AW-1:0] cfg_inc_i;
    logic          cfg_err_o;
    logic          rtc_o;
    logic          tick_o;
    logic [31:0]   tick_cnt_o;

    clint_rtc_gen #(.AccWidth(AW), .MinHalfPeriod(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .cfg_inc_i  (cfg_inc_i),
        .cfg_err_o  (cfg_err_o),
        .rtc_o      (rtc_o),
        .tick_o     (tick_o),
        .tick_cnt_o (tick_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   final_chk = 1'b0;
    bit   final_done = 1'b0;

    // Expected waveforms, bit i = value after enabled edge i+1.
    logic [3:0]  rtc_p4 = 4'b0110;   // inc=64 from acc=0: 0,1,1,0
    logic [3:0]  tick_p4 = 4'b0010;  // tick with the first high cycle
    logic [13:0] rtc32 = 14'b10011001111000;
    logic [13:0] rdy32 = 14'b11111110000001;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sel_name(input int s);
        case (s)
            S_RTC:   sel_name = "rtc_o";
            S_TICK:  sel_name = "tick_o";
            S_CNT:   sel_name = "tick_cnt_o";
            S_RDY:   sel_name = "cfg_ready_o";
            S_ERR:   sel_name = "cfg_err_o";
            S_ACC:   sel_name = "acc_q";
            default: sel_name = "unknown";
        endcase
    endfunction

    // Monitor: compares every expectation due at this cycle against the DUT.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.sel)
                S_RTC:   act = {31'd0, rtc_o};
                S_TICK:  act = {31'd0, tick_o};
                S_CNT:   act = tick_cnt_o;
                S_RDY:   act = {31'd0, cfg_ready_o};
                S_ERR:   act = {31'd0, cfg_err_o};
                S_ACC:   act = {24'd0, dut.acc_q};
                default: act = 32'hDEAD_BEEF;
            endcase
            total = total + 1;
            if (e.cyc != cyc || act !== e.v) begin
                bad = bad + 1;
                $display("FAIL %s cycle=%0d due=%0d got=%0h want=%0h",
                         sel_name(e.sel), cyc, e.cyc, act, e.v);
            end
        end
        if (final_chk && !final_done) begin
            total = total + 1;
            if (sb.size() != 0) begin
                bad = bad + 1;
                $display("FAIL drain left=%0d want=0", sb.size());
            end
            final_done = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input int sel, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc + k;
        e.sel = sel;
        e.v   = v;
        sb.push_back(e);
    endtask

    initial begin
        rst_i       = 1'b1;
        en_i        = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_inc_i   = 8'd0;

        // Reset values
        push(1, S_RTC, 0); push(1, S_TICK, 0); push(1, S_CNT, 0);
        push(1, S_RDY, 1); push(1, S_ERR, 0); push(1, S_ACC, 0);
        step(); step();
        rst_i = 1'b0;

        // Load inc=64 while disabled: applied on the following edge
        cfg_valid_i = 1'b1; cfg_inc_i = 8'd64;
        push(1, S_RDY, 0); push(2, S_RDY, 1);
        step();
        cfg_valid_i = 1'b0;
        step();

        // Period 4, five ticks in 20 enabled cycles
        en_i = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            push(k, S_RTC, rtc_p4[(k-1)%4]);
            push(k, S_TICK, tick_p4[(k-1)%4]);
        end
        push(20, S_CNT, 5); push(20, S_ACC, 0);
        repeat (20) step();

        // Drop enable for one cycle, then restart as 0,0,1,1
        push(2, S_RTC, 1); push(2, S_TICK, 1); push(2, S_CNT, 6);
        repeat (2) step();
        en_i = 1'b0;
        push(1, S_RTC, 0); push(1, S_TICK, 0); push(1, S_ACC, 0);
        step();
        en_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push(k, S_RTC, rtc_p4[k-1]);
            if (k == 2) push(k, S_CNT, 7);
        end
        repeat (4) step();

        // Reset during the high phase
        push(2, S_RTC, 1); push(2, S_CNT, 8);
        repeat (2) step();
        rst_i = 1'b1;
        push(1, S_RTC, 0); push(1, S_TICK, 0); push(1, S_CNT, 0); push(1, S_ACC, 0);
        step();
        rst_i = 1'b0; en_i = 1'b0;
        step();

        // inc=32 running, inc=64 written mid-period, held-off 200 ignored
        cfg_valid_i = 1'b1; cfg_inc_i = 8'd32;
        step();
        cfg_valid_i = 1'b0;
        step();
        en_i = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            push(k, S_RTC, rtc32[k-1]);
            push(k, S_RDY, rdy32[k-1]);
            if (k == 4)  push(k, S_CNT, 1);
            if (k == 5)  push(k, S_ERR, 0);
            if (k == 10) push(k, S_CNT, 2);
            if (k == 14) push(k, S_CNT, 3);
        end
        for (int k = 1; k <= 14; k++) begin
            cfg_valid_i = (k == 2) || (k == 4) || (k == 5);
            cfg_inc_i   = (k == 2) ? 8'd64 : 8'd200;
            step();
        end
        cfg_valid_i = 1'b0;

        // Over-limit write is clamped to 64 and flags a sticky error
        en_i = 1'b0;
        cfg_valid_i = 1'b1; cfg_inc_i = 8'd200;
        push(1, S_ERR, 1); push(1, S_RDY, 0); push(1, S_ACC, 0);
        step();
        cfg_valid_i = 1'b0;
        push(1, S_RDY, 1);
        step();
        en_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push(k, S_RTC, rtc_p4[k-1]);
            if (k == 2) push(k, S_CNT, 4);
        end
        repeat (4) step();
        en_i = 1'b0;
        cfg_valid_i = 1'b1; cfg_inc_i = 8'd3;
        push(1, S_ERR, 1);
        step();
        cfg_valid_i = 1'b0;
        push(1, S_ERR, 1);
        step();

        // inc=3 for 768 cycles: nine ticks, phase back to 0 every 256 cycles
        en_i = 1'b1;
        push(42, S_CNT, 4); push(43, S_CNT, 5); push(43, S_TICK, 1);
        push(128, S_ACC, 128); push(256, S_ACC, 0); push(512, S_ACC, 0);
        push(768, S_ACC, 0); push(768, S_CNT, 13); push(768, S_ERR, 1);
        repeat (768) step();

        // Only reset clears the sticky error
        rst_i = 1'b1;
        push(1, S_ERR, 0); push(1, S_CNT, 0); push(1, S_RDY, 1);
        step();
        rst_i = 1'b0; en_i = 1'b0;
        step();

        final_chk = 1'b1;
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
